// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Streaming add/subtract datapath. Operands are split into GROUP-bit
// carry-lookahead groups, and GPS groups form one pipeline stage. The carry
// ripples group-to-group inside a stage and is registered between stages, so
// the block returns one result per clock at latency L = WIDTH/(GROUP*GPS).
// Upper operand slices are skewed forward through delay registers, and lower
// result slices are de-skewed, so that all WIDTH bits land on sum_o together.
//
// Ports:
//   clk_in    - clock, rising edge
//   rst_in    - synchronous active-high reset
//   valid_in  - operands valid          ready_o  - can accept this cycle
//   a_in      - operand A               b_in     - operand B
//   c_in      - carry-in (add only)     sub_in   - 1: A-B, 0: A+B+c_in
//   valid_o   - result valid            ready_in - downstream accepts
//   sum_o     - result                  c_o      - carry out (sub: 1 = no borrow)
//   ov_o      - two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4,
  parameter int GPS   = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  output logic             valid_o,
  input  logic             ready_in,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
  output logic             ov_o
);

  localparam int SW = GROUP * GPS;   // bits resolved per stage
  localparam int L  = WIDTH / SW;    // number of stages = latency

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // The whole pipeline moves as one; it only stalls when the output is
  // occupied and the consumer refuses it.
  assign w_en      = ~valid_o | ready_in;
  assign ready_o   = w_en;

  // Subtraction is A + ~B + 1; c_in is ignored in that mode.
  assign w_b_eff   = sub_in ? ~b_in : b_in;
  assign w_cin_eff = sub_in ? 1'b1 : c_in;

  // One carry-lookahead group. Every internal carry is expanded as a
  // sum-of-products of generate/propagate terms and the group carry-in,
  // so no carry depends on another carry inside the group.
  // Returns {carry_out, sum}.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             cin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             t;
    g = a & b;
    p = a ^ b;
    for (int i = 0; i <= GROUP; i++) begin
      c[i] = cin;
      for (int j = 0; j < i; j++) c[i] = c[i] & p[j];
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int LO = k * SW;        // bits already resolved upstream
    localparam int HI = (k + 1) * SW;  // bits resolved after this stage

    logic [WIDTH-LO-1:0] w_a;          // operand bits not yet consumed
    logic [WIDTH-LO-1:0] w_b;
    logic                w_cin;
    logic                w_vin;
    logic [SW-1:0]       w_slice;
    logic                w_cout;
    logic [HI-1:0]       w_sum_next;

    logic                r_valid;
    logic                r_carry;
    logic [HI-1:0]       r_sum;

    if (k == 0) begin : g_head
      assign w_a        = a_in;
      assign w_b        = w_b_eff;
      assign w_cin      = w_cin_eff;
      assign w_vin      = valid_in;
      assign w_sum_next = w_slice;
    end else begin : g_body
      assign w_a        = g_stage[k-1].g_fwd.r_a;
      assign w_b        = g_stage[k-1].g_fwd.r_b;
      assign w_cin      = g_stage[k-1].r_carry;
      assign w_vin      = g_stage[k-1].r_valid;
      assign w_sum_next = {w_slice, g_stage[k-1].r_sum};
    end

    // Groups inside a stage ripple their carries into each other.
    // NOTE: every variable written here gets a value before any branch or
    // loop, so the block stays purely combinational (no latch).
    always_comb begin
      logic           w_c;
      logic [GROUP:0] w_grp;
      w_c     = w_cin;
      w_grp   = '0;
      w_slice = '0;
      for (int g = 0; g < GPS; g++) begin
        w_grp = cla_group(w_a[g*GROUP +: GROUP], w_b[g*GROUP +: GROUP], w_c);
        w_slice[g*GROUP +: GROUP] = w_grp[GROUP-1:0];
        w_c = w_grp[GROUP];
      end
      w_cout = w_c;
    end

    // Data only loads with a real operation, so bubbles leave the last
    // result visible on the outputs.
    // NOTE: state registers use non-blocking assignments so every stage
    // samples the previous stage's old value on the same edge.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_en) begin
        r_valid <= w_vin;
        if (w_vin) begin
          r_carry <= w_cout;
          r_sum   <= w_sum_next;
        end
      end
    end

    if (k < L - 1) begin : g_fwd
      logic [WIDTH-HI-1:0] r_a;
      logic [WIDTH-HI-1:0] r_b;
      // NOTE: operand delay registers carry no reset; their contents only
      // matter when qualified by r_valid, which is reset.
      always_ff @(posedge clk_in) begin
        if (w_en && w_vin) begin
          r_a <= w_a[WIDTH-LO-1:SW];
          r_b <= w_b[WIDTH-LO-1:SW];
        end
      end
    end else begin : g_last
      logic r_ov;
      // Carry into the MSB is recovered as a^b^sum at that bit, so the
      // overflow is (carry into MSB) xor (carry out of MSB).
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          r_ov <= 1'b0;
        end else if (w_en && w_vin) begin
          r_ov <= w_a[SW-1] ^ w_b[SW-1] ^ w_slice[SW-1] ^ w_cout;
        end
      end
    end
  end

  assign valid_o = g_stage[L-1].r_valid;
  assign sum_o   = g_stage[L-1].r_sum;
  assign c_o     = g_stage[L-1].r_carry;
  assign ov_o    = g_stage[L-1].g_last.r_ov;

endmodule
